pipe_hazard_unit: RTL

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destination registers after decode,
// selects forwarding sources, raises load-use or interlock stalls and branch flushes.
module pipe_hazard_unit #(
  parameter int AW     = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CW     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic [AW-1:0]            id_rs1,
  input  logic [AW-1:0]            id_rs2,
  input  logic [AW-1:0]            id_rd,
  input  logic                     ex_branch_taken,
  output logic                     stall,
  output logic                     flush_if_id,
  output logic                     flush_id_ex,
  output logic [$clog2(DEPTH)-1:0] fwd_a,
  output logic [$clog2(DEPTH)-1:0] fwd_b,
  output logic [CW-1:0]            stall_cnt,
  output logic [CW-1:0]            flush_cnt
);

  localparam int FW = $clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          isLoad;
  } entry_t;

  entry_t          entries [DEPTH];
  logic            hitA, hitB;
  logic [FW-1:0]   selA, selB;
  logic            loadUse;
  logic            hazard;
  logic            issue;

  function automatic logic srcMatch(input entry_t e, input logic used,
                                    input logic [AW-1:0] idx);
    return used && (idx != '0) && e.valid && e.regwrite && (e.rd == idx);
  endfunction

  // Scan oldest-to-youngest so the youngest eligible producer overwrites the select.
  // The WB entry is excluded: the register file already returns its value.
  always_comb begin
    // NOTE: defaults first, so no path through the loop leaves a value held (no latch).
    hitA = 1'b0;
    hitB = 1'b0;
    selA = '0;
    selB = '0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (srcMatch(entries[k], id_rs1_used, id_rs1)) begin
        hitA = 1'b1;
        selA = FW'(k + 1);
      end
      if (srcMatch(entries[k], id_rs2_used, id_rs2)) begin
        hitB = 1'b1;
        selB = FW'(k + 1);
      end
    end
  end

  assign loadUse = entries[0].isLoad &&
                   (srcMatch(entries[0], id_rs1_used, id_rs1) ||
                    srcMatch(entries[0], id_rs2_used, id_rs2));

  assign hazard      = (FWD_EN != 0) ? loadUse : (hitA || hitB);
  assign stall       = id_valid && !ex_branch_taken && hazard;
  assign issue       = id_valid && !stall && !ex_branch_taken;
  assign flush_if_id = ex_branch_taken;
  assign flush_id_ex = ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is a few flops, not a RAM, so every entry is reset;
      // a stale valid bit would otherwise fake a hazard right after reset.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      fwd_a     <= '0;
      fwd_b     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // NOTE: non-blocking, so each entry takes its neighbour's pre-edge value;
      // blocking here would collapse the whole shift into a single copy.
      entries[0] <= issue ? entry_t'{valid: 1'b1, rd: id_rd, regwrite: id_regwrite,
                                     isLoad: id_memread}
                          : entry_t'('0);
      for (int i = 1; i < DEPTH; i++) entries[i] <= entries[i-1];

      fwd_a <= (FWD_EN != 0 && issue && hitA) ? selA : '0;
      fwd_b <= (FWD_EN != 0 && issue && hitB) ? selB : '0;

      if (stall && stall_cnt != '1)           stall_cnt <= stall_cnt + CW'(1);
      if (ex_branch_taken && flush_cnt != '1) flush_cnt <= flush_cnt + CW'(1);
    end
  end

endmodule
